dmem_arbiter: RTL and testbench

//  Shares the single data_mem port between the pipeline MEM stage (CPU) and one

---
 rtl/dmem_arbiter.sv | 108 ++++++++++
 tb/tb_dmem_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Arbitrates the single data_mem port between the MEM-stage CPU and one external
// requester: CPU has priority, EXT gets bounded wait and bounded burst under contention.
module dmem_arbiter #(
   parameter int ADDR_WIDTH    = 8,
   parameter int DATA_WIDTH    = 32,
   parameter int EXT_WAIT_MAX  = 4,
   parameter int EXT_BURST_MAX = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_stall,
   input  logic                  ext_req,
   input  logic                  ext_we,
   input  logic [ADDR_WIDTH-1:0] ext_addr,
   input  logic [DATA_WIDTH-1:0] ext_wdata,
   output logic                  ext_gnt,
   output logic                  ext_rvalid,
   output logic [DATA_WIDTH-1:0] ext_rdata,
   output logic [ADDR_WIDTH-1:0] mem_a,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_wd,
   input  logic [DATA_WIDTH-1:0] mem_rd
);

   localparam int WW = $clog2(EXT_WAIT_MAX) + 1;
   localparam int BW = $clog2(EXT_BURST_MAX) + 1;
   localparam logic [WW-1:0] WAIT_LAST  = WW'(EXT_WAIT_MAX - 1);
   localparam logic [BW-1:0] BURST_LAST = BW'(EXT_BURST_MAX - 1);

   typedef enum logic {ST_CPU, ST_EXT} state_t;

   state_t                state_q, state_d;
   logic [WW-1:0]         wait_cnt_q, wait_cnt_d;
   logic [BW-1:0]         burst_cnt_q, burst_cnt_d;
   logic                  ext_rvalid_q, ext_rvalid_d;
   logic [DATA_WIDTH-1:0] ext_rdata_q, ext_rdata_d;
   logic                  gnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_CPU;
         wait_cnt_q   <= '0;
         burst_cnt_q  <= '0;
         ext_rvalid_q <= 1'b0;
         ext_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         burst_cnt_q  <= burst_cnt_d;
         ext_rvalid_q <= ext_rvalid_d;
         ext_rdata_q  <= ext_rdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      burst_cnt_d = burst_cnt_q;
      gnt         = 1'b0;
      cpu_stall   = 1'b0;
      mem_a       = cpu_addr;
      mem_wd      = cpu_wdata;
      mem_we      = cpu_req & cpu_we;
      case (state_q)
         ST_CPU: begin
            if (!ext_req)
               wait_cnt_d = '0;
            else if (cpu_req && wait_cnt_q != '1)
               wait_cnt_d = wait_cnt_q + WW'(1);
            // The CPU access of the handover cycle still completes on this edge.
            if (ext_req && (!cpu_req || wait_cnt_q == WAIT_LAST)) begin
               state_d     = ST_EXT;
               wait_cnt_d  = '0;
               burst_cnt_d = '0;
            end
         end
         ST_EXT: begin
            gnt       = ext_req;
            cpu_stall = cpu_req;
            mem_a     = ext_addr;
            mem_wd    = ext_wdata;
            mem_we    = ext_req & ext_we;
            if (gnt && burst_cnt_q != '1)
               burst_cnt_d = burst_cnt_q + BW'(1);
            // Burst limit only bites while the CPU is actually waiting.
            if (!ext_req || (cpu_req && gnt && burst_cnt_q == BURST_LAST))
               state_d = ST_CPU;
         end
         default: state_d = ST_CPU;
      endcase
   end

   always_comb begin
      ext_rvalid_d = gnt & ~ext_we;
      ext_rdata_d  = ext_rvalid_d ? mem_rd : ext_rdata_q;
   end

   assign ext_gnt    = gnt;
   assign ext_rvalid = ext_rvalid_q;
   assign ext_rdata  = ext_rdata_q;
   assign cpu_rdata  = mem_rd;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stimulus tasks push expected read data into
// queues, a negedge monitor pops and compares whenever a read result is presented.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, ext_req, ext_we;
   logic [7:0]  cpu_addr, ext_addr, mem_a;
   logic [31:0] cpu_wdata, ext_wdata, cpu_rdata, ext_rdata, mem_wd, mem_rd;
   logic        cpu_stall, ext_gnt, ext_rvalid, mem_we;

   logic [31:0] mem [0:255];
   logic [31:0] cpu_q[$];
   logic [31:0] ext_q[$];
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
      .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   // data_mem: combinational read, write on posedge
   assign mem_rd = mem[mem_a];
   always @(posedge clk) if (mem_we) mem[mem_a] <= mem_wd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compare every presented read result against the queued expectation
   always @(negedge clk) begin
      if (!rst) begin
         if (ext_rvalid) begin
            if (ext_q.size() == 0) chk("ext_rvalid_unexpected", 32'd1, 32'd0);
            else chk("ext_rdata", ext_rdata, ext_q.pop_front());
         end
         if (cpu_req && !cpu_we && !cpu_stall) begin
            if (cpu_q.size() == 0) chk("cpu_load_unexpected", 32'd1, 32'd0);
            else chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
         end
      end
   end

   // Holds the CPU request until it is no longer stalled; leaves cpu_req asserted.
   task automatic cpu_op(input logic we, input logic [7:0] a, input logic [31:0] d,
                         input logic [31:0] exp, output int waited);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      if (!we) cpu_q.push_back(exp);
      waited = 0;
      forever begin
         @(negedge clk);
         if (!cpu_stall) break;
         waited++;
         if (waited > 50) begin chk("cpu_stall_timeout", 32'd1, 32'd0); break; end
      end
      @(posedge clk); #1;
   endtask

   // Holds the EXT request until granted; leaves ext_req asserted.
   task automatic ext_op(input logic we, input logic [7:0] a, input logic [31:0] d,
                         input logic [31:0] exp, output int waited);
      ext_req = 1'b1; ext_we = we; ext_addr = a; ext_wdata = d;
      if (!we) ext_q.push_back(exp);
      waited = 0;
      forever begin
         @(negedge clk);
         if (ext_gnt) break;
         waited++;
         if (waited > 50) begin chk("ext_gnt_timeout", 32'd1, 32'd0); break; end
      end
      @(posedge clk); #1;
   endtask

   task automatic check_pattern(input int n, input logic [31:0] stall_exp,
                                input logic [31:0] gnt_exp);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         chk($sformatf("stall_cyc%0d", c), {31'd0, cpu_stall}, {31'd0, stall_exp[c]});
         chk($sformatf("gnt_cyc%0d", c), {31'd0, ext_gnt}, {31'd0, gnt_exp[c]});
      end
   endtask

   task automatic idle(input int n);
      cpu_req = 1'b0; ext_req = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
      rst = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;

      @(negedge clk);
      chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
      chk("rst_gnt", {31'd0, ext_gnt}, 32'd0);
      chk("rst_rvalid", {31'd0, ext_rvalid}, 32'd0);
      chk("rst_rdata", ext_rdata, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      idle(1);

      // EXT write with idle CPU: one-cycle entry latency
      ext_op(1'b1, 8'h10, 32'hDEAD_BEEF, 32'd0, w);
      chk("ext_wr_latency", w, 32'd1);
      idle(2);
      cpu_op(1'b0, 8'h10, 32'd0, 32'hDEAD_BEEF, w);
      chk("cpu_ld_nostall", w, 32'd0);
      idle(2);

      // EXT read returns one cycle after grant, then rvalid drops and data holds
      ext_op(1'b0, 8'h10, 32'd0, 32'hDEAD_BEEF, w);
      chk("ext_rd_latency", w, 32'd1);
      ext_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rvalid_one_cycle", {31'd0, ext_rvalid}, 32'd0);
      chk("rdata_held", ext_rdata, 32'hDEAD_BEEF);
      idle(2);

      // Sustained contention: 4 CPU cycles / 4 EXT cycles, CPU stores all land
      fork
         begin
            int wc;
            for (int i = 0; i < 10; i++) cpu_op(1'b1, 8'h40 + 8'(i), 32'h100 + i, 32'd0, wc);
            cpu_req = 1'b0;
         end
         begin
            int we2;
            for (int i = 0; i < 8; i++)
               ext_op(1'b0, 8'h30 + 8'(i), 32'd0, 32'hA500_0030 + i, we2);
            ext_req = 1'b0;
         end
         check_pattern(16, 32'h0000_F0F0, 32'h0000_F0F0);
      join
      for (int i = 0; i < 10; i++)
         chk($sformatf("cpu_store_%0d", i), mem[8'h40 + i], 32'h100 + i);
      idle(2);

      // CPU store on the last contended cycle is visible to the first EXT read
      fork
         begin
            int wc;
            cpu_op(1'b1, 8'h50, 32'd0, 32'd0, wc);
            cpu_op(1'b1, 8'h51, 32'd0, 32'd0, wc);
            cpu_op(1'b1, 8'h52, 32'd0, 32'd0, wc);
            cpu_op(1'b1, 8'h20, 32'd1, 32'd0, wc);
            cpu_op(1'b1, 8'h53, 32'd0, 32'd0, wc);
            cpu_req = 1'b0;
         end
         begin
            int we2;
            ext_op(1'b0, 8'h20, 32'd0, 32'd1, we2);
            ext_req = 1'b0;
            chk("ext_wait_contended", we2, 32'd4);
         end
      join
      idle(2);

      // EXT releases after 2 grants while CPU waits: one bubble, then CPU resumes
      fork
         begin
            int wc;
            for (int i = 0; i < 6; i++) cpu_op(1'b1, 8'h70 + 8'(i), 32'h7 + i, 32'd0, wc);
            cpu_req = 1'b0;
         end
         begin
            int we2;
            ext_op(1'b0, 8'h30, 32'd0, 32'hA500_0030, we2);
            ext_op(1'b0, 8'h31, 32'd0, 32'hA500_0031, we2);
            ext_req = 1'b0;
         end
         check_pattern(9, 32'h0000_0070, 32'h0000_0030);
      join
      idle(2);

      // Async reset while EXT owns and CPU is stalled
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h60; cpu_wdata = 32'h5;
      ext_req = 1'b1; ext_we = 1'b0; ext_addr = 8'h61;
      ext_q.push_back(32'hA500_0061);
      w = 0;
      forever begin
         @(negedge clk);
         if (ext_gnt) break;
         w++;
         if (w > 50) begin chk("rst_setup_timeout", 32'd1, 32'd0); break; end
      end
      @(negedge clk);
      chk("pre_rst_stall", {31'd0, cpu_stall}, 32'd1);
      chk("pre_rst_rvalid", {31'd0, ext_rvalid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_stall", {31'd0, cpu_stall}, 32'd0);
      chk("async_rst_gnt", {31'd0, ext_gnt}, 32'd0);
      chk("async_rst_rvalid", {31'd0, ext_rvalid}, 32'd0);
      chk("async_rst_rdata", ext_rdata, 32'd0);
      cpu_req = 1'b0; ext_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      idle(3);

      chk("ext_q_drained", ext_q.size(), 32'd0);
      chk("cpu_q_drained", cpu_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
